reg_wb_arbiter: RTL

Shares the register file's single write port among several writeback requesters (ALU, load unit, debug/CSR path). Each requester presents a valid/ready write request. A round-robin arbiter grants at most one per cycle. The granted write is registered and drives the register file's `waddr`/`wdata`/`we` one cycle later. Writes to x0 are absorbed, so the register file never sees them.

---
 rtl/reg_wb_pkg.sv | 20 ++
 rtl/reg_wb_arbiter_rr_pick.sv | 37 +++
 rtl/reg_wb_arbiter.sv | 93 +++++++++
 3 files changed

// File: rtl/reg_wb_pkg.sv
// Shared constants for the register-file writeback arbiter.
// Requester index map: 0 = ALU, 1 = load unit, 2 = debug/CSR path.
package reg_wb_pkg;

  localparam int XLEN     = 32;
  localparam int AW       = 5;
  localparam int NREQ     = 3;

  localparam int REQ_ALU  = 0;
  localparam int REQ_LOAD = 1;
  localparam int REQ_DBG  = 2;

  // A single requester still needs a 1-bit pointer field.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int PTR_W = ptr_width(NREQ);

endpackage

// File: rtl/reg_wb_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set request at or after i_ptr,
// wrapping modulo N, wins. Kept free of any register-file specifics.
module rr_pick #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [PW-1:0] o_idx,
  output logic          o_any
);

  logic [N-1:0] w_rot;
  int           w_sum;

  always_comb begin
    // Rotate so the pointer position lands at bit 0; the lowest set bit wins.
    w_rot = N'({i_req, i_req} >> i_ptr);
    o_any = |w_rot;
    w_sum = int'(i_ptr);
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_sum = int'(i_ptr) + k;
      end
    end
    if (w_sum >= N) begin
      w_sum = w_sum - N;
    end
    o_idx = PW'(w_sum);
    o_gnt = '0;
    for (int j = 0; j < N; j++) begin
      o_gnt[j] = o_any && (o_idx == PW'(j));
    end
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Shares the register file write port among NREQ writeback requesters.
// One round-robin grant per cycle; the granted write is registered one stage.
module reg_wb_arbiter #(
  parameter int NREQ = reg_wb_pkg::NREQ,
  parameter int XLEN = reg_wb_pkg::XLEN,
  parameter int AW   = reg_wb_pkg::AW
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NREQ-1:0]                         req_valid,
  input  logic [NREQ*AW-1:0]                      req_waddr,
  input  logic [NREQ*XLEN-1:0]                    req_wdata,
  output logic [NREQ-1:0]                         req_ready,
  input  logic                                    hold,
  output logic [AW-1:0]                           rf_waddr,
  output logic [XLEN-1:0]                         rf_wdata,
  output logic                                    rf_we,
  output logic                                    wr_pending,
  output logic [reg_wb_pkg::ptr_width(NREQ)-1:0]  rr_ptr
);

  import reg_wb_pkg::*;

  localparam int PW = ptr_width(NREQ);

  // Handshake: request i transfers on a rising edge where req_valid[i] and
  // req_ready[i] are both high; ready is one-hot or zero and never waits on
  // anything but valid, the pointer and hold. Requesters keep valid, address
  // and data stable until that edge.

  logic [NREQ-1:0] w_gnt;
  logic [PW-1:0]   w_idx;
  logic            w_any;
  logic            w_accept;
  logic [AW-1:0]   w_sel_addr;
  logic [XLEN-1:0] w_sel_data;
  logic [PW-1:0]   w_ptr_nxt;

  logic [AW-1:0]   r_waddr;
  logic [XLEN-1:0] r_wdata;
  logic            r_we;
  logic [PW-1:0]   r_ptr;

  rr_pick #(
    .N  (NREQ),
    .PW (PW)
  ) u_pick (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_sel_addr = req_waddr[i*AW +: AW];
        w_sel_data = req_wdata[i*XLEN +: XLEN];
      end
    end
  end

  assign w_accept  = w_any && !hold;
  assign req_ready = (hold || reset) ? '0 : w_gnt;
  assign w_ptr_nxt = (w_idx == PW'(NREQ - 1)) ? '0 : w_idx + PW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_waddr <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_ptr   <= '0;
    end else if (w_accept) begin
      r_waddr <= w_sel_addr;
      r_wdata <= w_sel_data;
      // x0 is accepted and consumes its turn, but never reaches the file.
      r_we    <= (w_sel_addr != '0);
      r_ptr   <= w_ptr_nxt;
    end else begin
      r_we    <= 1'b0;
    end
  end

  assign rf_waddr   = r_waddr;
  assign rf_wdata   = r_wdata;
  assign rf_we      = r_we;
  assign wr_pending = r_we;
  assign rr_ptr     = r_ptr;

endmodule
